// File: rtl/reg_load_if.sv
// Handshake and load-bus bundle between the two requesters, the arbiter and
// the register_a/register_b load inputs.
interface reg_load_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_dest;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic             req1_dest;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic [WIDTH-1:0] bus_data;
    logic             load_a;
    logic             load_b;
    logic             busy;
    logic             last_grant;

    modport master (
        output req0_valid, req0_dest, req0_data,
        output req1_valid, req1_dest, req1_data,
        input  req0_ready, req1_ready,
        input  bus_data, load_a, load_b, busy, last_grant
    );

    modport slave (
        input  req0_valid, req0_dest, req0_data,
        input  req1_valid, req1_dest, req1_data,
        output req0_ready, req1_ready,
        output bus_data, load_a, load_b, busy, last_grant
    );
endinterface

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter for the shared register load bus: accepts one transfer
// per handshake and presents it as a registered one-cycle load strobe.
module reg_load_arbiter #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    reg_load_if.slave lb
);
    typedef enum logic {IDLE, LOAD} state_t;

    state_t           state, state_nxt;
    logic             grant0, grant1;
    logic [WIDTH-1:0] win_data;
    logic             win_dest;

    // NOTE: state elements use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant0 || grant1) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            // On contention the requester that did not win last time goes first.
            grant0 = lb.req0_valid && (!lb.req1_valid || lb.last_grant);
            grant1 = lb.req1_valid && (!lb.req0_valid || !lb.last_grant);
        end
        lb.req0_ready = grant0;
        lb.req1_ready = grant1;
        lb.busy       = (state == LOAD);
    end

    assign win_data = grant1 ? lb.req1_data : lb.req0_data;
    assign win_dest = grant1 ? lb.req1_dest : lb.req0_dest;

    // Strobes default low each cycle, so they only ever last the LOAD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb.bus_data   <= '0;
            lb.load_a     <= 1'b0;
            lb.load_b     <= 1'b0;
            lb.last_grant <= 1'b1;
        end else begin
            lb.load_a <= 1'b0;
            lb.load_b <= 1'b0;
            if (grant0 || grant1) begin
                lb.bus_data   <= win_data;
                lb.load_a     <= !win_dest;
                lb.load_b     <= win_dest;
                lb.last_grant <= grant1;
            end
        end
    end
endmodule

// File: tb/tb_reg_load_arbiter.sv
// Scoreboard bench: a reference arbiter model queues each expected transfer,
// and a monitor pops and compares whenever the DUT raises a load strobe.
module tb_reg_load_arbiter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_load_if #(.WIDTH(W)) lb ();
    reg_load_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .lb(lb));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register models standing in for register_a / register_b.
    logic [W-1:0] reg_a = 8'd0;
    logic [W-1:0] reg_b = 8'd10;
    always @(posedge clk) begin
        if (lb.load_a) reg_a <= lb.bus_data;
        if (lb.load_b) reg_b <= lb.bus_data;
    end

    // Reference model: expected grants, state, last_grant and bus contents.
    logic         m_load;
    logic         m_last;
    logic [W-1:0] m_bus;
    logic [W:0]   sb[$];
    logic         eg0, eg1;
    assign eg0 = !rst && !m_load && lb.req0_valid && (!lb.req1_valid || m_last);
    assign eg1 = !rst && !m_load && lb.req1_valid && (!lb.req0_valid || !m_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_load <= 1'b0;
            m_last <= 1'b1;
            m_bus  <= '0;
            sb.delete();
        end else if (m_load) begin
            m_load <= 1'b0;
        end else if (eg0) begin
            sb.push_back({lb.req0_dest, lb.req0_data});
            m_load <= 1'b1;
            m_last <= 1'b0;
            m_bus  <= lb.req0_data;
        end else if (eg1) begin
            sb.push_back({lb.req1_dest, lb.req1_data});
            m_load <= 1'b1;
            m_last <= 1'b1;
            m_bus  <= lb.req1_data;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    logic       prev_strobe = 1'b0;
    int         cnt_a = 0;
    int         cnt_b = 0;
    logic [W:0] exp_item;
    always @(negedge clk) begin
        check("req0_ready", lb.req0_ready, eg0);
        check("req1_ready", lb.req1_ready, eg1);
        check("busy", lb.busy, m_load);
        check("last_grant", lb.last_grant, m_last);
        check("bus_data", lb.bus_data, m_bus);
        if (lb.load_a || lb.load_b) begin
            check("exclusive", lb.load_a && lb.load_b, 1'b0);
            check("single_cycle", prev_strobe, 1'b0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1'b1, 1'b0);
            end else begin
                exp_item = sb.pop_front();
                check("strobe_dest", lb.load_b, exp_item[W]);
                check("strobe_data", lb.bus_data, exp_item[W-1:0]);
            end
            if (lb.load_a) cnt_a <= cnt_a + 1;
            if (lb.load_b) cnt_b <= cnt_b + 1;
        end
        prev_strobe <= lb.load_a || lb.load_b;
    end

    task automatic drive(input int r, input logic v, input logic d, input logic [W-1:0] x);
        if (r == 0) begin
            lb.req0_valid = v; lb.req0_dest = d; lb.req0_data = x;
        end else begin
            lb.req1_valid = v; lb.req1_dest = d; lb.req1_data = x;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int   base_a, base_b;
    logic r0_seen, r1_seen;

    initial begin
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);

        // Reset then idle.
        cycles(2);
        rst = 1'b0;
        cycles(5);
        check("idle_load_a", lb.load_a, 1'b0);
        check("idle_bus", lb.bus_data, 8'h00);

        // Contention: req0 first after reset, then alternating.
        base_a = cnt_a; base_b = cnt_b;
        drive(0, 1'b1, 1'b0, 8'h11);
        drive(1, 1'b1, 1'b1, 8'h22);
        cycles(8);
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        cycles(3);
        check("contention_a", cnt_a - base_a, 2);
        check("contention_b", cnt_b - base_b, 2);
        check("contention_reg_b", reg_b, 8'h22);

        // Single transfer to register A.
        drive(0, 1'b1, 1'b0, 8'h2A);
        cycles(1);
        drive(0, 1'b0, 1'b0, 8'h00);
        cycles(1);
        check("single_reg_a", reg_a, 8'h2A);
        cycles(2);

        // Withdrawn request: req1 valid only during LOAD.
        base_b = cnt_b;
        drive(0, 1'b1, 1'b0, 8'h44);
        cycles(1);
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b1, 1'b1, 8'h55);
        cycles(1);
        drive(1, 1'b0, 1'b0, 8'h00);
        cycles(3);
        check("withdrawn_no_b", cnt_b - base_b, 0);
        check("withdrawn_reg_a", reg_a, 8'h44);

        // Reset mid-LOAD drops the pending load to register B.
        drive(1, 1'b1, 1'b1, 8'h7F);
        cycles(1);
        drive(1, 1'b0, 1'b0, 8'h00);
        #1 rst = 1'b1;
        #1 check("rst_clears_load_b", lb.load_b, 1'b0);
        check("rst_clears_busy", lb.busy, 1'b0);
        cycles(1);
        rst = 1'b0;
        cycles(2);
        check("rst_reg_b_kept", reg_b, 8'h22);

        // First contention after reset goes to req0.
        base_a = cnt_a; base_b = cnt_b;
        drive(0, 1'b1, 1'b0, 8'h66);
        drive(1, 1'b1, 1'b1, 8'h77);
        cycles(1);
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        cycles(3);
        check("post_rst_a", cnt_a - base_a, 1);
        check("post_rst_b", cnt_b - base_b, 0);

        // Random traffic honouring the hold-until-ready rule.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r0_seen = lb.req0_ready;
            r1_seen = lb.req1_ready;
            @(posedge clk);
            #1;
            if (!lb.req0_valid || r0_seen || $urandom_range(7) == 0)
                drive(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
            if (!lb.req1_valid || r1_seen || $urandom_range(7) == 0)
                drive(1, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
        end
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        cycles(4);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
